// File: rtl/per_pkt_framer.sv
// Transmit-side packet framer: gathers upstream bytes into bounded packets and
// replays each one as a len/data/last/valid burst into the packet buffer write port.
module per_pkt_framer #(
   parameter int unsigned MAX_LEN = 64,
   parameter int unsigned TIMEOUT = 1000,
   parameter int unsigned ADDR_W  = 8
) (
   input  logic       i_per_clk,
   input  logic       i_per_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic [7:0] o_per_len,
   output logic [7:0] o_per_data,
   output logic       o_per_last,
   output logic       o_per_valid
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {COLLECT, EMIT, GAP} state_t;

   state_t           state, state_nx;
   logic [7:0]       wr_cnt;
   logic [7:0]       rd_idx;
   logic [TMR_W-1:0] idle_tmr;
   logic [7:0]       mem [DEPTH];

   logic accept_c;
   logic close_len_c;
   logic close_tmo_c;
   logic last_rd_c;

   // o_ready is only high in COLLECT, so an accept implies COLLECT
   assign accept_c    = i_valid & o_ready;
   assign close_len_c = accept_c && ((wr_cnt + 8'd1) == 8'(MAX_LEN));
   assign close_tmo_c = (state == COLLECT) && !accept_c && (wr_cnt != 8'd0)
                        && (idle_tmr == TMR_W'(TIMEOUT - 1));
   assign last_rd_c   = (rd_idx == (o_per_len - 8'd1));

   // State register
   always_ff @(posedge i_per_clk or posedge i_per_rst) begin
      if (i_per_rst) state <= COLLECT;
      else           state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         COLLECT: if (close_len_c || close_tmo_c) state_nx = EMIT;
         EMIT:    if (last_rd_c) state_nx = GAP;
         GAP:     state_nx = COLLECT;
         default: state_nx = COLLECT;
      endcase
   end

   // Counters and burst outputs; o_per_len doubles as the latched packet length
   always_ff @(posedge i_per_clk or posedge i_per_rst) begin
      if (i_per_rst) begin
         o_ready     <= 1'b0;
         o_per_len   <= 8'd0;
         o_per_data  <= 8'd0;
         o_per_last  <= 1'b0;
         o_per_valid <= 1'b0;
         wr_cnt      <= 8'd0;
         rd_idx      <= 8'd0;
         idle_tmr    <= '0;
      end else begin
         o_ready <= (state_nx == COLLECT);
         case (state)
            COLLECT: begin
               rd_idx <= 8'd0;
               if (accept_c) begin
                  wr_cnt   <= wr_cnt + 8'd1;
                  idle_tmr <= '0;
               end else if ((wr_cnt != 8'd0) && !close_tmo_c) begin
                  idle_tmr <= idle_tmr + TMR_W'(1);
               end
               if (close_len_c)      o_per_len <= wr_cnt + 8'd1;
               else if (close_tmo_c) o_per_len <= wr_cnt;
            end
            EMIT: begin
               o_per_data  <= mem[ADDR_W'(rd_idx)];
               o_per_valid <= 1'b1;
               o_per_last  <= last_rd_c;
               rd_idx      <= rd_idx + 8'd1;
            end
            GAP: begin
               o_per_valid <= 1'b0;
               o_per_last  <= 1'b0;
               wr_cnt      <= 8'd0;
               idle_tmr    <= '0;
            end
            default: begin
               o_per_valid <= 1'b0;
               o_per_last  <= 1'b0;
            end
         endcase
      end
   end

   // Packet storage; contents are meaningless until rewritten, so no reset
   always_ff @(posedge i_per_clk) begin
      if (accept_c) mem[ADDR_W'(wr_cnt)] <= i_data;
   end

endmodule

// File: tb/tb_per_pkt_framer.sv
// Self-checking bench for per_pkt_framer: queue-based packet model plus
// directed boundary scenarios and a randomized stream.
module tb_per_pkt_framer;

   localparam int unsigned ML = 8;
   localparam int unsigned TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din = 8'd0;
   logic       vin = 1'b0;
   logic       o_ready, o_per_last, o_per_valid;
   logic [7:0] o_per_len, o_per_data;

   logic [7:0] din1 = 8'd0;
   logic       vin1 = 1'b0;
   logic       ready1, last1, valid1;
   logic [7:0] len1, data1;

   always #5 clk = ~clk;

   per_pkt_framer #(.MAX_LEN(ML), .TIMEOUT(TO), .ADDR_W(8)) u_dut (
      .i_per_clk(clk), .i_per_rst(rst), .i_data(din), .i_valid(vin),
      .o_ready(o_ready), .o_per_len(o_per_len), .o_per_data(o_per_data),
      .o_per_last(o_per_last), .o_per_valid(o_per_valid));

   per_pkt_framer #(.MAX_LEN(1), .TIMEOUT(TO), .ADDR_W(8)) u_dut1 (
      .i_per_clk(clk), .i_per_rst(rst), .i_data(din1), .i_valid(vin1),
      .o_ready(ready1), .o_per_len(len1), .o_per_data(data1),
      .o_per_last(last1), .o_per_valid(valid1));

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: open packet, bytes awaiting emission, expected outputs
   logic [7:0] m_pkt[$];
   logic [7:0] m_out[$];
   int         m_idle, m_busy;
   logic       m_ready, m_valid, m_last, m_acc;
   logic [7:0] m_len, m_data;

   // Observations gathered from the DUT
   logic [7:0] acc_q[$];
   logic [7:0] beat_d[$];
   logic       beat_l[$];
   logic [7:0] beat_n[$];
   int         beat_c[$];

   function automatic logic [18:0] obs();
      return {o_ready, o_per_valid, o_per_last, o_per_len, o_per_data};
   endfunction

   function automatic logic [18:0] mdl();
      return {m_ready, m_valid, m_last, m_len, m_data};
   endfunction

   function automatic void model_reset();
      m_pkt.delete(); m_out.delete();
      m_idle = 0; m_busy = 1;
      m_ready = 1'b0; m_valid = 1'b0; m_last = 1'b0; m_acc = 1'b0;
      m_len = 8'd0; m_data = 8'd0;
   endfunction

   // One rising edge: a closed packet goes out one byte per cycle starting the
   // edge after closing; ready stays low for len+1 cycles after the close.
   function automatic void model_edge(input logic v, input logic [7:0] d);
      logic rdy_pre;
      rdy_pre = m_ready;
      m_acc   = v && rdy_pre;
      if (m_out.size() > 0) begin
         m_data  = m_out.pop_front();
         m_valid = 1'b1;
         m_last  = (m_out.size() == 0);
      end else begin
         m_valid = 1'b0;
         m_last  = 1'b0;
      end
      if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) m_ready = 1'b1;
      end
      if (rdy_pre) begin
         if (m_acc) begin
            m_pkt.push_back(d);
            m_idle = 0;
         end else if (m_pkt.size() > 0) begin
            m_idle++;
         end
         if (m_pkt.size() == ML || (m_pkt.size() > 0 && m_idle == TO)) begin
            m_out   = m_pkt;
            m_len   = 8'(m_pkt.size());
            m_busy  = m_pkt.size() + 1;
            m_pkt.delete();
            m_idle  = 0;
            m_ready = 1'b0;
         end
      end
   endfunction

   function automatic void clear_obs();
      acc_q.delete(); beat_d.delete(); beat_l.delete(); beat_n.delete(); beat_c.delete();
      cyc = 0;
   endfunction

   task automatic run_cycle(input logic v, input logic [7:0] d);
      vin = v;
      din = d;
      if (v && o_ready) acc_q.push_back(d);
      @(posedge clk);
      model_edge(v, d);
      #1;
      if (o_per_valid) begin
         beat_d.push_back(o_per_data);
         beat_l.push_back(o_per_last);
         beat_n.push_back(o_per_len);
         beat_c.push_back(cyc);
      end
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1; vin = 1'b1; din = 8'hFF;
      repeat (5) begin
         @(posedge clk); #1;
         checks++;
         if (obs() !== 19'd0) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=0", obs());
         end
      end
      rst = 1'b0;
      model_reset();
      clear_obs();
      run_cycle(1'b0, 8'd0);
      checks++;
      if (o_ready !== 1'b1 || obs() !== mdl()) begin
         errors++;
         $display("FAIL reset_release got=%h exp=%h", obs(), mdl());
      end
   endtask

   task automatic test_timeout();
      logic [7:0] b [3];
      b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
      clear_obs();
      for (int c = 0; c < 30; c++) begin
         run_cycle(c < 3, (c < 3) ? b[c] : 8'h00);
         checks++;
         if (obs() !== mdl()) begin
            errors++;
            $display("FAIL timeout cyc=%0d got=%h exp=%h", c, obs(), mdl());
         end
      end
      checks++;
      if (beat_d.size() != 3 || beat_c[0] != 19) begin
         errors++;
         $display("FAIL timeout_beats got n=%0d first=%0d exp n=3 first=19",
                  beat_d.size(), (beat_c.size() > 0) ? beat_c[0] : -1);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (beat_d[i] !== b[i] || beat_n[i] !== 8'd3 || beat_l[i] !== (i == 2)) begin
               errors++;
               $display("FAIL timeout_beat%0d got d=%h len=%0d last=%b exp d=%h len=3 last=%b",
                        i, beat_d[i], beat_n[i], beat_l[i], b[i], (i == 2));
            end
         end
      end
   endtask

   task automatic test_length_close();
      int idx;
      idx = 0;
      clear_obs();
      for (int c = 0; c < 80; c++) begin
         if (idx < 20) begin
            if (o_ready) idx++;
            run_cycle(1'b1, 8'(idx - (o_ready ? 1 : 0)));
         end else begin
            run_cycle(1'b0, 8'h00);
         end
         checks++;
         if (obs() !== mdl()) begin
            errors++;
            $display("FAIL length cyc=%0d got=%h exp=%h", c, obs(), mdl());
         end
      end
      checks++;
      if (beat_d.size() != 20) begin
         errors++;
         $display("FAIL length_count got=%0d exp=20", beat_d.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            checks++;
            if (beat_d[i] !== 8'(i) || beat_l[i] !== (i == 7 || i == 15 || i == 19)
                || beat_n[i] !== ((i < 16) ? 8'd8 : 8'd4)) begin
               errors++;
               $display("FAIL length_beat%0d got d=%0d last=%b len=%0d", i, beat_d[i],
                        beat_l[i], beat_n[i]);
            end
         end
      end
   endtask

   task automatic test_timer_boundary();
      clear_obs();
      for (int c = 0; c < 45; c++) begin
         run_cycle(c == 0 || c == 16, (c == 0) ? 8'hC1 : 8'hC2);
         checks++;
         if (obs() !== mdl()) begin
            errors++;
            $display("FAIL boundary cyc=%0d got=%h exp=%h", c, obs(), mdl());
         end
      end
      checks++;
      if (beat_d.size() != 2 || beat_c[0] != 33 || beat_n[0] !== 8'd2
          || beat_d[0] !== 8'hC1 || beat_d[1] !== 8'hC2) begin
         errors++;
         $display("FAIL boundary_pkt got n=%0d first=%0d exp n=2 first=33 len=2",
                  beat_d.size(), (beat_c.size() > 0) ? beat_c[0] : -1);
      end
   endtask

   task automatic test_random();
      int pct;
      logic [7:0] r;
      clear_obs();
      pct = 50;
      for (int c = 0; c < 640; c++) begin
         if (c % 40 == 0) begin
            case ($urandom_range(0, 3))
               0: pct = 95;
               1: pct = 50;
               2: pct = 12;
               default: pct = 3;
            endcase
         end
         r = 8'($urandom);
         run_cycle((c < 600) && ($urandom_range(0, 99) < pct), r);
         checks++;
         if (obs() !== mdl()) begin
            errors++;
            $display("FAIL random cyc=%0d got=%h exp=%h", c, obs(), mdl());
         end
      end
      checks++;
      if (acc_q.size() != beat_d.size() || acc_q != beat_d) begin
         errors++;
         $display("FAIL random_stream got beats=%0d exp accepted=%0d", beat_d.size(),
                  acc_q.size());
      end
   endtask

   task automatic test_reset_mid_emit();
      int c;
      bit sent;
      clear_obs();
      c = 0;
      while (beat_d.size() < 3 && c < 60) begin
         run_cycle(c < 6, 8'h40 + 8'(c));
         checks++;
         if (obs() !== mdl()) begin
            errors++;
            $display("FAIL midemit_pre cyc=%0d got=%h exp=%h", c, obs(), mdl());
         end
         c++;
      end
      checks++;
      if (beat_d.size() != 3) begin
         errors++;
         $display("FAIL midemit_timeout got beats=%0d exp=3", beat_d.size());
      end
      rst = 1'b1;
      #1;
      checks++;
      if (obs() !== 19'd0) begin
         errors++;
         $display("FAIL midemit_async got=%h exp=0", obs());
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      clear_obs();
      sent = 1'b0;
      for (int k = 0; k < 30; k++) begin
         run_cycle(!sent, 8'h77);
         if (m_acc) sent = 1'b1;
         checks++;
         if (obs() !== mdl()) begin
            errors++;
            $display("FAIL midemit_post cyc=%0d got=%h exp=%h", k, obs(), mdl());
         end
      end
      checks++;
      if (beat_d.size() != 1 || beat_d[0] !== 8'h77 || beat_n[0] !== 8'd1 || beat_l[0] !== 1'b1) begin
         errors++;
         $display("FAIL midemit_pkt got n=%0d exp single beat 77 len 1", beat_d.size());
      end
   endtask

   task automatic test_max_len_one();
      logic [7:0] b [2];
      logic [7:0] seen[$];
      int         at[$];
      int         idx;
      logic       acc;
      b[0] = 8'hA5; b[1] = 8'h5A;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         vin1 = (idx < 2);
         din1 = (idx < 2) ? b[idx] : 8'h00;
         acc  = vin1 && ready1;
         @(posedge clk);
         if (acc) idx++;
         #1;
         if (valid1) begin
            seen.push_back(data1);
            at.push_back(c);
            checks++;
            if (last1 !== 1'b1 || len1 !== 8'd1 || ready1 !== 1'b0) begin
               errors++;
               $display("FAIL len1_beat cyc=%0d got last=%b len=%0d rdy=%b exp 1/1/0",
                        c, last1, len1, ready1);
            end
         end
      end
      vin1 = 1'b0;
      checks++;
      if (seen.size() != 2 || seen[0] !== 8'hA5 || seen[1] !== 8'h5A || (at[1] - at[0]) != 3) begin
         errors++;
         $display("FAIL len1_bursts got n=%0d exp two beats A5,5A spaced 3", seen.size());
      end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_length_close();
      test_timer_boundary();
      test_random();
      test_reset_mid_emit();
      test_max_len_one();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
